// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with hex decode, per-slot anode blanking
// and a shadow/active double buffer that only swaps on frame boundaries.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 16,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk_i,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [4*N_DIGITS-1:0]   num_i,
    input  logic                    num_valid_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    output logic [6:0]              cath_o,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     an_o,
    output logic                    frame_o
);

    localparam int unsigned NUM_W   = 4 * N_DIGITS;
    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIGIT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYC - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);
    localparam logic               INACT      = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic [NUM_W-1:0]     sh_num_q, sh_num_d, act_num_q, act_num_d;
    logic [N_DIGITS-1:0]  sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                 pending_q, pending_d;
    logic                 commit_c;

    logic [3:0]           nib_c;
    logic [6:0]           seg_c;
    logic                 dp_bit_c;
    logic [N_DIGITS-1:0]  onehot_c;
    logic [N_DIGITS-1:0]  an_d;
    logic [6:0]           cath_d;
    logic                 dp_d;
    logic                 frame_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan sequencing and double-buffer next state; a commit marks the start of a frame.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        digit_d   = digit_q;
        sh_num_d  = sh_num_q;
        sh_dp_d   = sh_dp_q;
        act_num_d = act_num_q;
        act_dp_d  = act_dp_q;
        pending_d = pending_q;
        commit_c  = 1'b0;

        if (num_valid_i) begin
            sh_num_d  = num_i;
            sh_dp_d   = dp_i;
            pending_d = 1'b1;
        end

        if (!en_i) begin
            state_d = IDLE;
            presc_d = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    presc_d  = '0;
                    digit_d  = '0;
                    commit_c = 1'b1;
                end
                BLANK: begin
                    presc_d = presc_q + PRESC_W'(1);
                    if (presc_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (presc_q == PRESC_LAST) begin
                        state_d = BLANK;
                        presc_d = '0;
                        if (digit_q == DIGIT_LAST) begin
                            digit_d  = '0;
                            commit_c = 1'b1;
                        end else begin
                            digit_d = digit_q + DIGIT_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                    digit_d = '0;
                end
            endcase
        end

        // A strobe on the commit cycle already sits in sh_*_d, so it goes straight through.
        if (commit_c && pending_d) begin
            act_num_d = sh_num_d;
            act_dp_d  = sh_dp_d;
            pending_d = 1'b0;
        end
    end

    // Output values follow the next state so they line up with the registered state.
    always_comb begin
        nib_c    = 4'(act_num_d >> {digit_d, 2'b00});
        seg_c    = hex_decode(nib_c);
        dp_bit_c = 1'(act_dp_d >> digit_d);
        onehot_c = N_DIGITS'(1) << digit_d;
        an_d     = {N_DIGITS{INACT}};
        cath_d   = {7{INACT}};
        dp_d     = INACT;
        frame_d  = commit_c;
        if (state_d != IDLE) begin
            cath_d = seg_c ^ {7{INACT}};
            dp_d   = dp_bit_c ^ INACT;
        end
        if (state_d == DRIVE) begin
            an_d = onehot_c ^ {N_DIGITS{INACT}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            digit_q   <= '0;
            sh_num_q  <= '0;
            sh_dp_q   <= '0;
            act_num_q <= '0;
            act_dp_q  <= '0;
            pending_q <= 1'b0;
            an_o      <= {N_DIGITS{INACT}};
            cath_o    <= {7{INACT}};
            dp_o      <= INACT;
            frame_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            sh_num_q  <= sh_num_d;
            sh_dp_q   <= sh_dp_d;
            act_num_q <= act_num_d;
            act_dp_q  <= act_dp_d;
            pending_q <= pending_d;
            an_o      <= an_d;
            cath_o    <= cath_d;
            dp_o      <= dp_d;
            frame_o   <= frame_d;
        end
    end

endmodule
